apb_timer_slave: RTL



---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_wait_gen.sv | 62 ++++++
 rtl/apb_timer_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared constants for the APB timer slave and its wait-state generator:
// register byte offsets within the 32-byte window, CTRL bit positions, and
// the width and maximum value of the wait-state count.
// ---------------------------------------------------------------------------
package apb_pkg;

  // Byte offsets of the registers (PADDR[4:0] with PADDR[1:0] forced to 0).
  localparam logic [4:0] CTRL_OFS    = 5'h00;
  localparam logic [4:0] LOAD_OFS    = 5'h04;
  localparam logic [4:0] VALUE_OFS   = 5'h08;
  localparam logic [4:0] INTSTAT_OFS = 5'h0C;
  localparam logic [4:0] WAIT_OFS    = 5'h10;

  // CTRL register layout.
  localparam int CTRL_W      = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQEN  = 1;
  localparam int CTRL_RELOAD = 2;

  // Wait-state count: 0..MAX_WAIT extra access cycles.
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 15;

endpackage

// File: rtl/apb_wait_gen.sv
// ---------------------------------------------------------------------------
// apb_wait_gen
// Inserts a programmable number of wait states into every APB transfer.
// The count is loaded from wait_i in the setup phase and counted down on
// each PCLKEN-qualified access cycle; PREADY rises once it reaches zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pclken_i        APB clock enable; the counter only moves when high
//   psel_i          APB select
//   penable_i       APB access phase
//   wait_i          wait states to insert in the next transfer
//   access_o        PSEL & PENABLE, held low while in reset
//   pready_o        transfer complete (combinational)
// ---------------------------------------------------------------------------
module apb_wait_gen
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pclken_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [WAIT_W-1:0] wait_i,
  output logic              access_o,
  output logic              pready_o
);

  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              run_q;

  // NOTE: every variable assigned in always_comb gets a default on the first
  // line so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wcnt_d = wcnt_q;
    if (pclken_i && psel_i) begin
      if (!penable_i) begin
        wcnt_d = wait_i;
      end else if (wcnt_q != '0) begin
        wcnt_d = wcnt_q - WAIT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      run_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      run_q  <= 1'b1;
    end
  end

  // run_q keeps the slave silent while reset is asserted even if the bridge
  // holds PSEL/PENABLE high through it (wcnt is 0 in reset).
  assign access_o = run_q & psel_i & penable_i;
  assign pready_o = access_o & (wcnt_q == '0);

endmodule

// File: rtl/apb_timer_slave.sv
// ---------------------------------------------------------------------------
// apb_timer_slave
// APB3 peripheral with a programmable down-counting timer, a level
// interrupt, and programmable APB wait states.
//
// Registers (byte offset):
//   0x00 CTRL    RW  [0] EN, [1] IRQEN, [2] RELOAD
//   0x04 LOAD    RW  reload value; writing it also loads VALUE
//   0x08 VALUE   RO  current count
//   0x0C INTSTAT W1C [0] expiry flag
//   0x10 WAIT    RW  [3:0] wait states per transfer
//
// Ports:
//   HCLK, HRESETn                 clock, asynchronous active-low reset
//   PCLKEN                        APB/timer clock enable
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA   APB request
//   PRDATA, PREADY, PSLVERR       APB response
//   TIMER_IRQ                     INTSTAT & CTRL.IRQEN
// ---------------------------------------------------------------------------
module apb_timer_slave
  import apb_pkg::*;
#(
  parameter int ADDRWIDTH  = 16,
  parameter int DATAWIDTH  = 32,
  parameter int TIMERWIDTH = 32,
  parameter int WAITRST    = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMER_IRQ
);

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [TIMERWIDTH-1:0] load_q, load_d;
  logic [TIMERWIDTH-1:0] value_q, value_d;
  logic                  intstat_q, intstat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic                  access;
  logic [4:0]            ofs;
  logic                  ofs_valid;
  logic                  err;
  logic                  wr_en;
  logic                  expire;
  logic [DATAWIDTH-1:0]  rdata;
  logic                  unused_paddr_lsbs;

  apb_wait_gen u_wait_gen (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .pclken_i  (PCLKEN),
    .psel_i    (PSEL),
    .penable_i (PENABLE),
    .wait_i    (wait_q),
    .access_o  (access),
    .pready_o  (PREADY)
  );

  // Byte lanes are not decoded; every access is treated as a full word.
  assign unused_paddr_lsbs = ^PADDR[1:0];
  assign ofs               = {PADDR[4:2], 2'b00};

  always_comb begin
    case (ofs)
      CTRL_OFS, LOAD_OFS, VALUE_OFS, INTSTAT_OFS, WAIT_OFS: ofs_valid = 1'b1;
      default:                                              ofs_valid = 1'b0;
    endcase
  end

  assign err     = ~ofs_valid | (|PADDR[ADDRWIDTH-1:5]) | (PWRITE & (ofs == VALUE_OFS));
  assign wr_en   = PCLKEN & PREADY & PWRITE & ~err;
  assign PSLVERR = PREADY & err;

  always_comb begin
    rdata = '0;
    case (ofs)
      CTRL_OFS:    rdata[CTRL_W-1:0]     = ctrl_q;
      LOAD_OFS:    rdata[TIMERWIDTH-1:0] = load_q;
      VALUE_OFS:   rdata[TIMERWIDTH-1:0] = value_q;
      INTSTAT_OFS: rdata[0]              = intstat_q;
      WAIT_OFS:    rdata[WAIT_W-1:0]     = wait_q;
      default:     ;
    endcase
  end

  // Read data is shown for the whole access phase (including wait states).
  assign PRDATA = (access && !PWRITE && !err) ? rdata : '0;

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    intstat_d = intstat_q;
    wait_d    = wait_q;
    expire    = 1'b0;

    if (PCLKEN && ctrl_q[CTRL_EN]) begin
      if (value_q > TIMERWIDTH'(1)) begin
        value_d = value_q - TIMERWIDTH'(1);
      end else if (value_q == TIMERWIDTH'(1)) begin
        value_d = ctrl_q[CTRL_RELOAD] ? load_q : '0;
        expire  = 1'b1;
      end else if (ctrl_q[CTRL_RELOAD]) begin
        // A zero count only restarts from LOAD in periodic mode; in one-shot
        // mode zero is the terminal state after the single expiry.
        value_d = load_q;
      end
    end

    // Bus writes come after the timer update so a LOAD write wins over the
    // decrement on the same edge.
    if (wr_en) begin
      case (ofs)
        CTRL_OFS:    ctrl_d = PWDATA[CTRL_W-1:0];
        LOAD_OFS: begin
          load_d  = PWDATA[TIMERWIDTH-1:0];
          value_d = PWDATA[TIMERWIDTH-1:0];
        end
        INTSTAT_OFS: if (PWDATA[0]) intstat_d = 1'b0;
        WAIT_OFS:    wait_d = PWDATA[WAIT_W-1:0];
        default:     ;
      endcase
    end

    // An expiry on the same edge as a clear keeps the flag set.
    if (expire) intstat_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      intstat_q <= 1'b0;
      wait_q    <= WAIT_W'(WAITRST);
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      intstat_q <= intstat_d;
      wait_q    <= wait_d;
    end
  end

  assign TIMER_IRQ = intstat_q & ctrl_q[CTRL_IRQEN];

endmodule
